// File: rtl/b_to_g_enc.sv
// b_to_g_enc: streaming binary-to-Gray encoder with a 2-entry output buffer
// and a delivered-beat counter. Define GRAY_ADJ_CHECK_EN to enable adj_err.
module b_to_g_enc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] binary,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gray,
    output logic [CNT_W-1:0] count,
    output logic             adj_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] enc_d;
    logic             push;
    logic             pop;

    // Handshake qualification and the encoded value of the offered beat.
    always_comb begin
        in_ready  = ~rst & (state_q != FULL);
        out_valid = (state_q != EMPTY);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        enc_d     = binary ^ (binary >> 1);
        count_d   = count_q + CNT_ONE;
    end

    // Occupancy FSM, buffer entries and delivered-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                count_q <= count_d;
            end
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= enc_d;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= enc_d;
                    end else if (push) begin
                        tail_q  <= enc_d;
                        state_q <= FULL;
                    end else if (pop) begin
                        // head keeps the last delivered code
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign gray  = head_q;
    assign count = count_q;

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic [WIDTH-1:0] diff;

    // Remember the last delivered code to judge the next head against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else if (pop) begin
            prev_q      <= head_q;
            have_prev_q <= 1'b1;
        end
    end

    // A legal Gray step differs from the previous code in exactly one bit.
    always_comb begin
        diff    = head_q ^ prev_q;
        adj_err = out_valid & have_prev_q & ($countones(diff) != 1);
    end
`else
    assign adj_err = 1'b0;
`endif

endmodule
